// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_if
//   Command bus from the host into the encoder plus the instruction-memory
//   write port driven by the encoder.
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high. The host holds the command fields steady while
//   cmd_valid is high. cmd_ready never depends combinationally on cmd_valid.
//   imem_we is a single-cycle strobe qualifying imem_addr/imem_wdata.
//
//   master : host side (drives the command, observes the memory port)
//   slave  : encoder side (accepts the command, drives the memory port)
// ---------------------------------------------------------------------------
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_fmt;
  logic [6:0]        cmd_op;
  logic [2:0]        cmd_funct3;
  logic [6:0]        cmd_funct7;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              cmd_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output cmd_valid, cmd_fmt, cmd_op, cmd_funct3, cmd_funct7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_fmt, cmd_op, cmd_funct3, cmd_funct7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//   Packs field-level RV32I commands into 32-bit instruction words and writes
//   them to consecutive instruction-memory word addresses from a programmed
//   base. One word per two cycles (ACCEPT then WRITE).
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a session (honoured only in IDLE)
//   base_addr   : first word address of the session
//   bus         : command handshake + imem write port (slave modport)
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse at session end
//   count       : words written in the current session
//   err         : sticky error (encoding violation or overflow)
//   dbg_state   : current FSM state (0 IDLE, 1 ACCEPT, 2 WRITE, 3 DONE)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       word_q;
  logic              last_q;
  logic              err_q;
  logic              at_limit;

  // -------------------------------------------------------------------------
  // Encoder: pure function of the command fields
  // -------------------------------------------------------------------------
  logic signed [31:0] simm;
  logic [31:0]        imm;
  logic [31:0]        enc_raw;
  logic               enc_bad;
  logic [31:0]        enc_word;

  assign imm  = bus.cmd_imm;
  assign simm = bus.cmd_imm;

  always_comb begin
    enc_raw = NOP;
    enc_bad = 1'b0;
    case (bus.cmd_fmt)
      3'b000: begin // I
        enc_raw = {imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, bus.cmd_op};
        enc_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      3'b001: begin // S
        enc_raw = {imm[11:5], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                   imm[4:0], bus.cmd_op};
        enc_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      3'b010: begin // B
        enc_raw = {imm[12], imm[10:5], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                   imm[4:1], imm[11], bus.cmd_op};
        enc_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      end
      3'b011: begin // J
        enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], bus.cmd_rd, bus.cmd_op};
        enc_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      end
      3'b100: begin // U: caller passes the full value, low 12 bits must be clear
        enc_raw = {imm[31:12], bus.cmd_rd, bus.cmd_op};
        enc_bad = (imm[11:0] != 12'd0);
      end
      3'b101: begin // R
        enc_raw = {bus.cmd_funct7, bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                   bus.cmd_rd, bus.cmd_op};
        enc_bad = 1'b0;
      end
      default: begin
        enc_raw = NOP;
        enc_bad = 1'b1;
      end
    endcase
    // A bad command still produces a write (as NOP) so later addresses line up.
    enc_word = enc_bad ? NOP : enc_raw;
  end

  assign count_inc = count_q + 1'b1;
  assign at_limit  = (count_inc == DEPTH_C);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM next state and outputs (all outputs are state decodes or registers)
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    bus.cmd_ready  = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = addr_q;
    bus.imem_wdata = word_q;
    busy           = (state != IDLE);
    done           = 1'b0;
    count          = count_q;
    err            = err_q;
    dbg_state      = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = WRITE;
      end
      WRITE: begin
        bus.imem_we = 1'b1;
        state_nxt   = (last_q || at_limit) ? DONE : ACCEPT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ACCEPT: begin
          if (bus.cmd_valid) begin
            word_q <= enc_word;
            last_q <= bus.cmd_last;
            if (enc_bad) err_q <= 1'b1;
          end
        end
        WRITE: begin
          // Address wraps naturally in ADDR_W bits.
          addr_q  <= addr_q + 1'b1;
          count_q <= count_inc;
          // Hitting the session limit without a last command is an overflow.
          if (at_limit && !last_q) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
//   Directed bench for instr_encoder_loader. Two instances: the default
//   configuration (a) and a small one with ADDR_W=2, DEPTH=4 (b) for the
//   wrap/overflow case. Expected writes and done results are queued when
//   stimulus is issued; a monitor per instance pops and compares them.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic [7:0] base_a;
  logic [1:0] base_b;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;
  logic [8:0] count_a;
  logic [2:0] count_b;
  logic [1:0] st_a, st_b;

  instr_encoder_loader_if #(.ADDR_W(8)) ifa ();
  instr_encoder_loader_if #(.ADDR_W(2)) ifb ();

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .count(count_a), .err(err_a), .dbg_state(st_a)
  );

  instr_encoder_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .count(count_b), .err(err_b), .dbg_state(st_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] exp_a_q[$];   // {addr, data}
  logic [9:0]  done_a_q[$];  // {err, count}
  logic [33:0] exp_b_q[$];
  logic [3:0]  done_b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with empty expected queue", name);
  endtask

  // Monitors
  always @(negedge clk) begin : mon_a
    logic [39:0] e;
    logic [9:0]  d;
    if (ifa.imem_we) begin
      if (exp_a_q.size() == 0) unexpected("wr_a");
      else begin
        e = exp_a_q.pop_front();
        check("wr_a_addr", ifa.imem_addr, e[39:32]);
        check("wr_a_data", ifa.imem_wdata, e[31:0]);
      end
    end
    if (done_a) begin
      if (done_a_q.size() == 0) unexpected("done_a");
      else begin
        d = done_a_q.pop_front();
        check("done_a_err", err_a, d[9]);
        check("done_a_count", count_a, d[8:0]);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [33:0] e;
    logic [3:0]  d;
    if (ifb.imem_we) begin
      if (exp_b_q.size() == 0) unexpected("wr_b");
      else begin
        e = exp_b_q.pop_front();
        check("wr_b_addr", ifb.imem_addr, e[33:32]);
        check("wr_b_data", ifb.imem_wdata, e[31:0]);
      end
    end
    if (done_b) begin
      if (done_b_q.size() == 0) unexpected("done_b");
      else begin
        d = done_b_q.pop_front();
        check("done_b_err", err_b, d[3]);
        check("done_b_count", count_b, d[2:0]);
      end
    end
  end

  // Driver tasks (entered and left at a falling edge)
  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic last);
    ifa.cmd_fmt = fmt; ifa.cmd_op = op; ifa.cmd_funct3 = f3; ifa.cmd_funct7 = f7;
    ifa.cmd_rd = rd; ifa.cmd_rs1 = rs1; ifa.cmd_rs2 = rs2; ifa.cmd_imm = imm;
    ifa.cmd_last = last;
    ifb.cmd_fmt = fmt; ifb.cmd_op = op; ifb.cmd_funct3 = f3; ifb.cmd_funct7 = f7;
    ifb.cmd_rd = rd; ifb.cmd_rs1 = rs1; ifb.cmd_rs2 = rs2; ifb.cmd_imm = imm;
    ifb.cmd_last = last;
  endtask

  task automatic start_session(input bit sel, input logic [7:0] base);
    if (sel) begin start_b = 1'b1; base_b = base[1:0]; end
    else     begin start_a = 1'b1; base_a = base; end
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check(sel ? "start_b_ready" : "start_a_ready", sel ? ifb.cmd_ready : ifa.cmd_ready, 1);
  endtask

  // Presents the already-set fields; returns at the falling edge of the
  // cycle after the handshake (the WRITE cycle) or after a timeout.
  task automatic send(input bit sel, output bit ok);
    ok = 1'b0;
    if (sel) ifb.cmd_valid = 1'b1; else ifa.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sel ? ifb.cmd_ready : ifa.cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    ifa.cmd_valid = 1'b0;
    ifb.cmd_valid = 1'b0;
  endtask

  task automatic send_ok(input bit sel, input string name);
    bit ok;
    send(sel, ok);
    check(name, ok, 1);
  endtask

  // Watchdog
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Main stimulus
  initial begin : main
    bit ok;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
    ifa.cmd_valid = 1'b0; ifb.cmd_valid = 1'b0;
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", ifa.cmd_ready, 0);
    check("rst_we", ifa.imem_we, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_count", count_a, 0);
    check("rst_addr", ifa.imem_addr, 0);
    check("rst_wdata", ifa.imem_wdata, 0);

    // Session 1: add / addi(last) from base 0x10
    start_session(0, 8'h10);
    check("s1_busy", busy_a, 1);
    exp_a_q.push_back({8'h10, 32'h002081B3});
    set_fields(3'd5, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send_ok(0, "s1_hs_add");
    exp_a_q.push_back({8'h11, 32'h00500093});
    done_a_q.push_back({1'b0, 9'd2});
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    send_ok(0, "s1_hs_addi");
    check("s1_we_timing", ifa.imem_we, 1);
    @(negedge clk);
    check("s1_done_timing", done_a, 1);
    @(negedge clk);
    check("s1_idle_busy", busy_a, 0);
    check("s1_idle_done", done_a, 0);

    // Session 2: sw / beq(last)
    start_session(0, 8'h20);
    exp_a_q.push_back({8'h20, 32'h0020A423});
    set_fields(3'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send_ok(0, "s2_hs_sw");
    exp_a_q.push_back({8'h21, 32'hFE208EE3});
    done_a_q.push_back({1'b0, 9'd2});
    set_fields(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1);
    send_ok(0, "s2_hs_beq");
    check("s2_err", err_a, 0);
    repeat (2) @(negedge clk);

    // Session 3: lui / jal / misaligned branch (last)
    start_session(0, 8'h30);
    exp_a_q.push_back({8'h30, 32'h123452B7});
    set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    send_ok(0, "s3_hs_lui");
    exp_a_q.push_back({8'h31, 32'h008000EF});
    set_fields(3'd3, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    send_ok(0, "s3_hs_jal");
    check("s3_err_before", err_a, 0);
    exp_a_q.push_back({8'h32, 32'h00000013});
    done_a_q.push_back({1'b1, 9'd3});
    set_fields(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
    send_ok(0, "s3_hs_bad_b");
    check("s3_err_after", err_a, 1);
    repeat (2) @(negedge clk);

    // Session 4: err clear on start, I out of range, illegal fmt,
    // backpressure with an ignored start, then a normal last command.
    start_session(0, 8'h50);
    check("s4_err_cleared", err_a, 0);
    exp_a_q.push_back({8'h50, 32'h00000013});
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    send_ok(0, "s4_hs_bad_i");
    check("s4_err_bad_i", err_a, 1);
    exp_a_q.push_back({8'h51, 32'h00000013});
    set_fields(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    send_ok(0, "s4_hs_bad_fmt");
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_a = 1'b1;
      base_a  = 8'h99;
      check("s4_bp_ready", ifa.cmd_ready, 1);
      check("s4_bp_we", ifa.imem_we, 0);
      @(negedge clk);
    end
    start_a = 1'b0;
    exp_a_q.push_back({8'h52, 32'h00500093});
    done_a_q.push_back({1'b1, 9'd3});
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    send_ok(0, "s4_hs_addi");
    repeat (2) @(negedge clk);

    // Small instance: wrap from base 3 and overflow at DEPTH=4
    start_session(1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      logic [1:0]  a;
      w = {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13};
      a = 2'(3 + i);
      exp_b_q.push_back({a, w});
      if (i == 3) done_b_q.push_back({1'b1, 3'd4});
      set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i + 1), 1'b0);
      send_ok(1, "b_hs");
    end
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    send(1, ok);
    check("b_no_5th_hs", ok, 0);
    check("b_final_count", count_b, 4);
    check("b_final_err", err_b, 1);
    check("b_final_busy", busy_b, 0);

    // Reset while a write is pending
    start_session(0, 8'h40);
    exp_a_q.push_back({8'h40, 32'h123452B7});
    set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    send_ok(0, "r_hs_lui");
    @(negedge clk);
    set_fields(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    ifa.cmd_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ifa.cmd_valid = 1'b0;
    check("r_we", ifa.imem_we, 0);
    check("r_ready", ifa.cmd_ready, 0);
    check("r_busy", busy_a, 0);
    check("r_done", done_a, 0);
    check("r_err", err_a, 0);
    check("r_count", count_a, 0);
    check("r_addr", ifa.imem_addr, 0);
    check("r_wdata", ifa.imem_wdata, 0);
    check("r_state", st_a, 0);
    repeat (3) @(negedge clk);

    check("end_exp_a", exp_a_q.size(), 0);
    check("end_done_a", done_a_q.size(), 0);
    check("end_exp_b", exp_b_q.size(), 0);
    check("end_done_b", done_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader. It accepts field-level instruction commands over a valid/ready handshake and packs each into a 32-bit RV32I word in R/I/S/B/U/J format. It then writes the word into the instruction memory at consecutive word addresses, starting from a programmed base. It sits between the test/boot host and the instruction memory, and produces exactly the encodings the core's controller decodes.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `DEPTH`, default 256: maximum words per load session, at most 2^ADDR_W.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a load session; honoured only in IDLE.
- `base_addr`  in  ADDR_W  first word address of the session.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  encoder can accept a command.
- `cmd_fmt`  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110/111 illegal.
- `cmd_op`  in  7  opcode field [6:0].
- `cmd_funct3`  in  3  funct3 [14:12]; ignored for U/J.
- `cmd_funct7`  in  7  funct7 [31:25]; R format only.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  5 each  register indices.
- `cmd_imm`  in  32  signed byte offset or immediate. For U it is the full value, so bits [11:0] must be 0.
- `cmd_last`  in  1  final command of the session.
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  write word address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at session end.
- `count`  out  ADDR_W+1  words written in the current session.
- `err`  out  1  sticky error flag, cleared by `start` or `rst`.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - `start` loads `base_addr` into the address register, clears `count` and `err`, and moves to ACCEPT.
  - `start` is ignored in every other state.
- ACCEPT:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, the encoded word and `cmd_last` are registered and the state moves to WRITE.
- WRITE:
  - `imem_we`=1 for exactly this cycle; `imem_addr` is the current address and `imem_wdata` is the registered word.
  - On exit: address +1 modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0), and `count` +1.
  - If the registered last flag is set, or the new `count` equals `DEPTH`, the next state is DONE; otherwise ACCEPT.
- DONE: `done`=1 for one cycle, then IDLE.
- Overflow: if `count`=`DEPTH` is reached without `cmd_last`, `err` is set and the session ends. No further writes occur in that session.
- Encoding, with `imm` = `cmd_imm`:
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}. For shifts, the caller supplies funct7 in imm[11:5].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Range checks. On any violation the word is replaced by NOP 0x00000013, `err` is set, and the write still occurs, so addresses stay aligned.
  - I/S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0]=0.
  - J: imm must lie in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0] must be 0.
  - Illegal `cmd_fmt` is also a violation.
- The block does not check `cmd_op`; it is passed through verbatim.

## Timing
- Reset values: state IDLE; `cmd_ready`, `imem_we`, `busy`, `done`, `err` = 0; `count` = 0; `imem_addr` = 0; `imem_wdata` = 0.
- `rst` mid-session aborts immediately. A pending write is not issued, and no `done` pulse is produced.
- Cycle timing:
  - `start` at cycle t gives ACCEPT at t+1.
  - A handshake at cycle n gives `imem_we` at n+1.
  - The earliest next handshake is at n+2, so sustained throughput is 1 word per 2 cycles.
- The last handshake at cycle n gives the write at n+1, `done` at n+2, and IDLE at n+3.
- `count` and `imem_addr` update on the edge ending WRITE. `count` is visible as final during DONE.
- `cmd_ready` is a registered state decode with no combinational path from `cmd_valid`.
- `err` is set on the edge ending ACCEPT for an encoding violation, or ending WRITE for overflow. It holds until the next accepted `start` or `rst`.

## Test plan
- Basic session: `start` with base 0x10, then:
  - R `add x3,x1,x2` (op 0x33) -> write 0x002081B3 at 0x10.
  - I `addi x1,x0,5` -> 0x00500093 at 0x11.
  - `last` on the second command -> `done` pulse with `count`=2.
- S and B formats:
  - `sw x2,8(x1)` -> 0x0020A423.
  - `beq x1,x2,-4` -> 0xFE208EE3.
  - `err` stays 0.
- U and J formats:
  - `lui x5,0x12345000` -> 0x123452B7.
  - `jal x1,8` -> 0x008000EF.
  - B with imm=3 -> NOP 0x00000013 written and `err`=1.
- Wrap and overflow with ADDR_W=2, DEPTH=4:
  - Base 3, 5 commands without `last` -> writes to addresses 3,0,1,2.
  - Then `done`, `err`=1, `count`=4, and no 5th handshake is accepted.
- Backpressure and illegal start:
  - `cmd_valid` low for 3 cycles in ACCEPT -> no write.
  - `start` asserted while busy -> ignored; address unchanged.
- Reset mid-operation:
  - `rst` in the WRITE-pending cycle -> no `imem_we`, all outputs 0 next cycle, state IDLE.
